// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the 4-requester round-robin grant arbiter.
// Holds requester count, index width, FSM encoding and the wrapping increment.
package rr_grant_arbiter_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_e;

   // Index arithmetic is IDX_W bits wide, so 3+1 wraps to 0 naturally.
   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      return idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/rr_prio_enc4.sv
// Combinational rotating priority encoder: the first set request at or after
// ptr_i (wrapping) wins, and its index is reported as a 2-bit code.
module rr_prio_enc4
   import rr_grant_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] win_idx_o,
   output logic             win_any_o
);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [IDX_W-1:0]   off;

   always_comb begin
      // Rotate so the highest-priority requester lands in bit 0.
      dbl = {req_i, req_i} >> ptr_i;
      rot = dbl[N_REQ-1:0];
      off = '0;
      casez (rot)
         4'b???1: off = 2'd0;
         4'b??10: off = 2'd1;
         4'b?100: off = 2'd2;
         4'b1000: off = 2'd3;
         default: off = 2'd0;
      endcase
      win_idx_o = ptr_i + off;
      win_any_o = |req_i;
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for one shared resource: grants are held until the owner
// releases or the hold limit expires, followed by one turnaround cycle.
module rr_grant_arbiter
   import rr_grant_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   arb_state_e       state_q;
   logic [IDX_W-1:0] ptr_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic [CNT_W-1:0] hold_cnt_d;
   logic [N_REQ-1:0] gnt_q;
   logic [IDX_W-1:0] gnt_idx_q;
   logic             timeout_q;
   logic [IDX_W-1:0] win_idx;
   logic             win_any;
   logic             owner_req;
   logic             hold_hit;

   rr_prio_enc4 u_prio_enc (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .win_idx_o (win_idx),
      .win_any_o (win_any)
   );

   assign owner_req  = req[gnt_idx_q];
   assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));
   assign hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         gnt_q      <= '0;
         gnt_idx_q  <= '0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (win_any) begin
                  gnt_q      <= N_REQ'(1) << win_idx;
                  gnt_idx_q  <= win_idx;
                  hold_cnt_q <= CNT_W'(1);
                  state_q    <= GRANT;
               end
            end
            GRANT: begin
               if (!owner_req || hold_hit) begin
                  gnt_q     <= '0;
                  gnt_idx_q <= '0;
                  ptr_q     <= idx_inc(gnt_idx_q);
                  state_q   <= GAP;
                  // A voluntary release in the limit cycle is not a timeout.
                  timeout_q <= owner_req;
               end else begin
                  hold_cnt_q <= hold_cnt_d;
               end
            end
            GAP:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = |gnt_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus randomized requests
// compared against an owner/pointer reference model, at MAX_HOLD 8 and 0.
module tb_rr_grant_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;

   logic [3:0] gnt8, gnt0;
   logic [1:0] idx8, idx0;
   logic       vld8, vld0, to8, to0;
   logic [7:0] obs8, obs0;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: index 0 mirrors MAX_HOLD=8, index 1 mirrors MAX_HOLD=0.
   int m_owner[2];
   int m_ptr[2];
   int m_held[2];
   int m_dead[2];
   bit m_to[2];

   always #5 clk = ~clk;

   rr_grant_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_dut8 (
      .clk(clk), .rst(rst), .req(req),
      .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(vld8), .timeout(to8)
   );

   rr_grant_arbiter #(.MAX_HOLD(0), .CNT_W(4)) u_dut0 (
      .clk(clk), .rst(rst), .req(req),
      .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0), .timeout(to0)
   );

   assign obs8 = {gnt8, idx8, vld8, to8};
   assign obs0 = {gnt0, idx0, vld0, to0};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_owner[i] <= -1;
            m_ptr[i]   <= 0;
            m_held[i]  <= 0;
            m_dead[i]  <= 0;
            m_to[i]    <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            automatic int lim = (i == 0) ? 8 : 0;
            automatic int w   = -1;
            m_to[i] <= 1'b0;
            if (m_owner[i] >= 0) begin
               if (!req[m_owner[i]]) begin
                  m_ptr[i]   <= (m_owner[i] + 1) % 4;
                  m_owner[i] <= -1;
                  m_dead[i]  <= 1;
               end else if (lim != 0 && m_held[i] == lim) begin
                  m_ptr[i]   <= (m_owner[i] + 1) % 4;
                  m_owner[i] <= -1;
                  m_dead[i]  <= 1;
                  m_to[i]    <= 1'b1;
               end else begin
                  m_held[i] <= (m_held[i] < 15) ? m_held[i] + 1 : 15;
               end
            end else if (m_dead[i] > 0) begin
               m_dead[i] <= m_dead[i] - 1;
            end else begin
               for (int k = 0; k < 4; k++)
                  if (w < 0 && req[(m_ptr[i] + k) % 4]) w = (m_ptr[i] + k) % 4;
               if (w >= 0) begin
                  m_owner[i] <= w;
                  m_held[i]  <= 1;
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      req = 4'b0000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      req = 4'b0000;
      rst = 1'b1;
      tick();
      if (obs8 !== 8'h00) begin n_fail++; $display("FAIL reset_state8 got=%b exp=%b", obs8, 8'h00); end
      n_checks++;
      if (obs0 !== 8'h00) begin n_fail++; $display("FAIL reset_state0 got=%b exp=%b", obs0, 8'h00); end
      n_checks++;
      rst = 1'b0;
      req = 4'b0100;
      tick();
      if (obs8 !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin n_fail++; $display("FAIL pre_rst_grant got=%b exp=%b", obs8, {4'b0100, 2'd2, 1'b1, 1'b0}); end
      n_checks++;
      #2 rst = 1'b1;
      #1;
      if (obs8 !== 8'h00) begin n_fail++; $display("FAIL async_rst8 got=%b exp=%b", obs8, 8'h00); end
      n_checks++;
      if (obs0 !== 8'h00) begin n_fail++; $display("FAIL async_rst0 got=%b exp=%b", obs0, 8'h00); end
      n_checks++;
      tick();
      rst = 1'b0;
      req = 4'b0001;
      tick();
      if (obs8 !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL post_rst_grant got=%b exp=%b", obs8, {4'b0001, 2'd0, 1'b1, 1'b0}); end
      n_checks++;
      req = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_rotation();
      logic [7:0] e;
      do_reset();
      req = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         e = {4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0};
         for (int c = 0; c < 3; c++) begin
            if (obs8 !== e) begin n_fail++; $display("FAIL rot_grant k=%0d c=%0d got=%b exp=%b", k, c, obs8, e); end
            n_checks++;
            if (obs0 !== e) begin n_fail++; $display("FAIL rot_grant0 k=%0d c=%0d got=%b exp=%b", k, c, obs0, e); end
            n_checks++;
            if (c == 2) req[k % 4] = 1'b0;
            tick();
         end
         for (int g = 0; g < 2; g++) begin
            if (obs8 !== 8'h00) begin n_fail++; $display("FAIL rot_gap k=%0d g=%0d got=%b exp=%b", k, g, obs8, 8'h00); end
            n_checks++;
            req = 4'b1111;
            tick();
         end
      end
      req = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b1010;
      tick();
      for (int c = 0; c < 8; c++) begin
         if (obs8 !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL to_hold c=%0d got=%b exp=%b", c, obs8, {4'b0010, 2'd1, 1'b1, 1'b0}); end
         n_checks++;
         tick();
      end
      if (obs8 !== {4'b0000, 2'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL to_pulse got=%b exp=%b", obs8, {4'b0000, 2'd0, 1'b0, 1'b1}); end
      n_checks++;
      if (obs0 !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL to_disabled got=%b exp=%b", obs0, {4'b0010, 2'd1, 1'b1, 1'b0}); end
      n_checks++;
      tick();
      if (obs8 !== 8'h00) begin n_fail++; $display("FAIL to_idle got=%b exp=%b", obs8, 8'h00); end
      n_checks++;
      tick();
      if (obs8 !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin n_fail++; $display("FAIL to_next got=%b exp=%b", obs8, {4'b1000, 2'd3, 1'b1, 1'b0}); end
      n_checks++;
      req = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_wrap();
      do_reset();
      req = 4'b0100;
      tick();
      req = 4'b1001;
      repeat (3) tick();
      if (obs8 !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin n_fail++; $display("FAIL wrap_3 got=%b exp=%b", obs8, {4'b1000, 2'd3, 1'b1, 1'b0}); end
      n_checks++;
      req = 4'b0001;
      tick();
      req = 4'b1001;
      repeat (2) tick();
      if (obs8 !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL wrap_0 got=%b exp=%b", obs8, {4'b0001, 2'd0, 1'b1, 1'b0}); end
      n_checks++;
      req = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_lone();
      int bad = 0;
      do_reset();
      req = 4'b0100;
      tick();
      for (int c = 0; c < 50; c++) begin
         if (obs0 !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            n_fail++;
            bad++;
            if (bad < 4) $display("FAIL lone_hold c=%0d got=%b exp=%b", c, obs0, {4'b0100, 2'd2, 1'b1, 1'b0});
         end
         n_checks++;
         tick();
      end
      req = 4'b0000;
      tick();
      if (obs0 !== 8'h00) begin n_fail++; $display("FAIL lone_release got=%b exp=%b", obs0, 8'h00); end
      n_checks++;
      repeat (3) tick();
   endtask

   task automatic test_simultaneous();
      do_reset();
      req = 4'b0010;
      tick();
      for (int c = 0; c < 8; c++) begin
         if (obs8 !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL sim_hold c=%0d got=%b exp=%b", c, obs8, {4'b0010, 2'd1, 1'b1, 1'b0}); end
         n_checks++;
         if (c == 7) req = 4'b0000;
         tick();
      end
      if (obs8 !== 8'h00) begin n_fail++; $display("FAIL sim_no_timeout got=%b exp=%b", obs8, 8'h00); end
      n_checks++;
      req = 4'b0110;
      repeat (2) tick();
      if (obs8 !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin n_fail++; $display("FAIL sim_ptr got=%b exp=%b", obs8, {4'b0100, 2'd2, 1'b1, 1'b0}); end
      n_checks++;
      req = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_random();
      logic [7:0] e;
      logic [3:0] mask;
      int bad = 0;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            if (m_owner[i] >= 0) e = {4'(1 << m_owner[i]), 2'(m_owner[i]), 1'b1, m_to[i]};
            else                 e = {4'b0000, 2'd0, 1'b0, m_to[i]};
            if (((i == 0) ? obs8 : obs0) !== e) begin
               n_fail++;
               bad++;
               if (bad < 6) $display("FAIL rand_dut%0d c=%0d got=%b exp=%b", i, c, (i == 0) ? obs8 : obs0, e);
            end
            n_checks++;
         end
         rst = (rst == 1'b1) ? 1'b0 : ($urandom_range(199) == 0);
         mask = '0;
         for (int b = 0; b < 4; b++) mask[b] = ($urandom_range(5) == 0);
         req = req ^ mask;
      end
      rst = 1'b0;
      req = 4'b0000;
      repeat (3) tick();
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_timeout();
      test_wrap();
      test_lone();
      test_simultaneous();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
